// File: rtl/qspi_pkg.sv
// Opcodes, scheduler state encoding and opcode classification helpers shared by
// the QSPI command scheduler and its bench.
package qspi_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_SE4K  = 8'h20;
    localparam logic [7:0] OP_BE32K = 8'h52;
    localparam logic [7:0] OP_BE64K = 8'hD8;
    localparam logic [7:0] OP_RST   = 8'h99;
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRE_ISSUE  = 3'd1,
        PRE_WAIT   = 3'd2,
        CMD_ISSUE  = 3'd3,
        CMD_WAIT   = 3'd4,
        POLL_ISSUE = 3'd5,
        POLL_WAIT  = 3'd6,
        RESP       = 3'd7
    } sched_state_t;

    function automatic logic needs_wren(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_SE4K) || (op == OP_BE32K) || (op == OP_BE64K);
    endfunction

    // Every WREN-prefixed command leaves the device busy, so the two sets coincide.
    function automatic logic needs_poll(input logic [7:0] op);
        return needs_wren(op);
    endfunction

    function automatic logic needs_rsten(input logic [7:0] op);
        return op == OP_RST;
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        return needs_wren(op) || needs_rsten(op) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/qspi_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is taken.
module qspi_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
        last_d = last_q;
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    // Pointer resets to "requester 1 went last" so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/qspi_cmd_scheduler.sv
// Sequences two requesters onto the QSPI engine with WREN/RSTEN prefixes and RDSR WIP polling.
// Define QSPI_SCHED_POLL_TIMEOUT_EN to fail a request after POLL_MAX busy status reads.
module qspi_cmd_scheduler
    import qspi_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [15:0] POLL_MAX = 16'd1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [15:0]           req_op,
    input  logic [2*ADDR_W-1:0]   req_addr,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic                  rsp_err,
    output logic                  eng_valid,
    output logic [7:0]            eng_op,
    output logic [ADDR_W-1:0]     eng_addr,
    input  logic                  eng_ready,
    input  logic                  eng_done,
    input  logic [7:0]            eng_status,
    output logic                  busy
);

    sched_state_t      state_q, state_d;
    logic              owner_q, owner_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              eng_valid_q, eng_valid_d;
    logic [7:0]        eng_op_q, eng_op_d;
    logic [ADDR_W-1:0] eng_addr_q, eng_addr_d;
    logic              busy_q, busy_d;

    logic [1:0]        gnt;
    logic              accept;
    logic [7:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        owner_mask;
    logic [6:0]        status_unused;

`ifdef QSPI_SCHED_POLL_TIMEOUT_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        poll_expired;
    assign poll_expired = ({1'b0, poll_cnt_q} + 17'd1) >= {1'b0, POLL_MAX};
`else
    logic [15:0] poll_max_unused;
    assign poll_max_unused = POLL_MAX;
`endif

    assign status_unused = eng_status[7:1];
    assign accept        = (state_q == IDLE) && !rst && (req_valid != 2'b00);
    assign sel_op        = gnt[1] ? req_op[15:8] : req_op[7:0];
    assign sel_addr      = gnt[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign owner_mask    = owner_q ? 2'b10 : 2'b01;

    qspi_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        op_d        = op_q;
        addr_d      = addr_q;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        eng_valid_d = eng_valid_q;
        eng_op_d    = eng_op_q;
        eng_addr_d  = eng_addr_q;
`ifdef QSPI_SCHED_POLL_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gnt[1];
                    op_d    = sel_op;
                    addr_d  = sel_addr;
                    if (!is_legal(sel_op)) begin
                        state_d     = RESP;
                        rsp_valid_d = gnt;
                        rsp_err_d   = 1'b1;
                    end else if (needs_wren(sel_op) || needs_rsten(sel_op)) begin
                        state_d     = PRE_ISSUE;
                        eng_valid_d = 1'b1;
                        eng_op_d    = needs_wren(sel_op) ? OP_WREN : OP_RSTEN;
                        eng_addr_d  = '0;
                    end else begin
                        state_d     = CMD_ISSUE;
                        eng_valid_d = 1'b1;
                        eng_op_d    = sel_op;
                        eng_addr_d  = sel_addr;
                    end
                end
            end
            PRE_ISSUE, CMD_ISSUE, POLL_ISSUE: begin
                if (eng_valid_q && eng_ready) begin
                    eng_valid_d = 1'b0;
                    case (state_q)
                        PRE_ISSUE: state_d = PRE_WAIT;
                        CMD_ISSUE: state_d = CMD_WAIT;
                        default:   state_d = POLL_WAIT;
                    endcase
                end
            end
            PRE_WAIT: begin
                if (eng_done) begin
                    state_d     = CMD_ISSUE;
                    eng_valid_d = 1'b1;
                    eng_op_d    = op_q;
                    eng_addr_d  = addr_q;
                end
            end
            CMD_WAIT: begin
                if (eng_done) begin
                    if (needs_poll(op_q)) begin
                        state_d     = POLL_ISSUE;
                        eng_valid_d = 1'b1;
                        eng_op_d    = OP_RDSR;
                        eng_addr_d  = '0;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = owner_mask;
                    end
                end
            end
            POLL_WAIT: begin
                if (eng_done) begin
                    if (!eng_status[0]) begin
                        state_d     = RESP;
                        rsp_valid_d = owner_mask;
`ifdef QSPI_SCHED_POLL_TIMEOUT_EN
                    end else if (poll_expired) begin
                        state_d     = RESP;
                        rsp_valid_d = owner_mask;
                        rsp_err_d   = 1'b1;
                    end else begin
                        poll_cnt_d  = poll_cnt_q + 16'd1;
                        state_d     = POLL_ISSUE;
                        eng_valid_d = 1'b1;
                        eng_op_d    = OP_RDSR;
                        eng_addr_d  = '0;
                    end
`else
                    end else begin
                        state_d     = POLL_ISSUE;
                        eng_valid_d = 1'b1;
                        eng_op_d    = OP_RDSR;
                        eng_addr_d  = '0;
                    end
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef QSPI_SCHED_POLL_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            eng_valid_q <= 1'b0;
            eng_op_q    <= '0;
            eng_addr_q  <= '0;
            busy_q      <= 1'b0;
`ifdef QSPI_SCHED_POLL_TIMEOUT_EN
            poll_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            eng_valid_q <= eng_valid_d;
            eng_op_q    <= eng_op_d;
            eng_addr_q  <= eng_addr_d;
            busy_q      <= busy_d;
`ifdef QSPI_SCHED_POLL_TIMEOUT_EN
            poll_cnt_q  <= poll_cnt_d;
`endif
        end
    end

    // req_ready is the only combinational output: it is the handshake with the held request.
    assign req_ready = accept ? gnt : 2'b00;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign eng_valid = eng_valid_q;
    assign eng_op    = eng_op_q;
    assign eng_addr  = eng_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_qspi_cmd_scheduler.sv
// Randomized bench for qspi_cmd_scheduler against a transaction-level model of
// arbitration, prefix/poll sequencing and response timing.
module tb_qspi_cmd_scheduler;

    localparam logic [15:0] POLL_MAX_TB = 16'd4;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_op;
    logic [47:0] req_addr;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic        eng_valid;
    logic [7:0]  eng_op;
    logic [23:0] eng_addr;
    logic        eng_ready;
    logic        eng_done;
    logic [7:0]  eng_status;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    bit          pend_vld[2];
    logic [7:0]  pend_op[2];
    logic [23:0] pend_addr[2];
    int          pend_nb[2];
    int          last_g;

    qspi_cmd_scheduler #(.ADDR_W(24), .POLL_MAX(POLL_MAX_TB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .eng_valid  (eng_valid),
        .eng_op     (eng_op),
        .eng_addr   (eng_addr),
        .eng_ready  (eng_ready),
        .eng_done   (eng_done),
        .eng_status (eng_status),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        req_valid = {pend_vld[1], pend_vld[0]};
        req_op    = {pend_op[1], pend_op[0]};
        req_addr  = {pend_addr[1], pend_addr[0]};
    endtask

    task automatic set_req(input int r, input logic [7:0] op, input logic [23:0] ad, input int nb);
        pend_vld[r]  = 1'b1;
        pend_op[r]   = op;
        pend_addr[r] = ad;
        pend_nb[r]   = nb;
    endtask

    // Engine side of one command: wait for it, hold it a random time, accept, optionally complete.
    task automatic serve(output logic [7:0] op_o, output logic [23:0] ad_o,
                         input logic [7:0] st, input bit do_done);
        int cyc;
        cyc = 0;
        while (eng_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("eng_valid_wait", 64'(eng_valid), 64'd1);
        op_o = eng_op;
        ad_o = eng_addr;
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("eng_hold", {31'd0, eng_valid, eng_op, eng_addr}, {31'd0, 1'b1, op_o, ad_o});
            chk("ready_quiet", 64'(req_ready), 64'd0);
        end
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        chk("eng_drop", 64'(eng_valid), 64'd0);
        if (do_done) begin
            repeat ($urandom_range(0, 2)) begin
                eng_ready = 1'($urandom);
                tick();
            end
            eng_ready  = 1'b0;
            eng_done   = 1'b1;
            eng_status = st;
            tick();
            eng_done   = 1'b0;
            eng_status = 8'($urandom);
        end
    endtask

    task automatic run_one();
        int          g, cyc, nb, npoll;
        logic [1:0]  gmask;
        logic [7:0]  op, got_op, st;
        logic [23:0] ad, got_ad;
        logic [7:0]  exp_op[$];
        logic [23:0] exp_ad[$];
        bit          exp_ck[$];
        bit          exp_err;

        g = (pend_vld[0] && pend_vld[1]) ? ((last_g == 1) ? 0 : 1) : (pend_vld[1] ? 1 : 0);
        gmask = (g == 1) ? 2'b10 : 2'b01;
        drive_reqs();
        #1;
        cyc = 0;
        while (req_ready == 2'b00 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("grant", 64'(req_ready), 64'(gmask));
        if (req_ready == 2'b00) return;
        last_g = g;
        op = pend_op[g];
        ad = pend_addr[g];
        nb = pend_nb[g];

        exp_err = 1'b0;
        if (op == 8'h03) begin
            exp_op.push_back(8'h03); exp_ad.push_back(ad); exp_ck.push_back(1'b1);
        end else if (op == 8'h99) begin
            exp_op.push_back(8'h66); exp_ad.push_back(24'd0); exp_ck.push_back(1'b0);
            exp_op.push_back(8'h99); exp_ad.push_back(ad);    exp_ck.push_back(1'b1);
        end else if (op == 8'h02 || op == 8'h20 || op == 8'h52 || op == 8'hD8) begin
            exp_op.push_back(8'h06); exp_ad.push_back(24'd0); exp_ck.push_back(1'b0);
            exp_op.push_back(op);    exp_ad.push_back(ad);    exp_ck.push_back(1'b1);
            npoll = nb + 1;
`ifdef QSPI_SCHED_POLL_TIMEOUT_EN
            if (nb >= int'(POLL_MAX_TB)) begin
                npoll   = int'(POLL_MAX_TB);
                exp_err = 1'b1;
            end
`endif
            repeat (npoll) begin
                exp_op.push_back(8'h05); exp_ad.push_back(24'd0); exp_ck.push_back(1'b1);
            end
        end else begin
            exp_err = 1'b1;
        end

        tick();
        pend_vld[g] = 1'b0;
        drive_reqs();
        chk("busy_rise", 64'(busy), 64'd1);
        chk("ready_after_accept", 64'(req_ready), 64'd0);
        if (exp_op.size() == 0) begin
            chk("illegal_rsp", 64'(rsp_valid), 64'(gmask));
            chk("illegal_err", 64'(rsp_err), 64'd1);
            chk("illegal_no_eng", 64'(eng_valid), 64'd0);
        end else begin
            chk("eng_latency", 64'(eng_valid), 64'd1);
            npoll = 0;
            foreach (exp_op[i]) begin
                st = 8'($urandom);
                if (exp_op[i] == 8'h05) begin
                    st[0] = (npoll < nb);
                    npoll++;
                end
                serve(got_op, got_ad, st, 1'b1);
                chk("eng_op", 64'(got_op), 64'(exp_op[i]));
                if (exp_ck[i]) chk("eng_addr", 64'(got_ad), 64'(exp_ad[i]));
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(gmask));
            chk("rsp_err", 64'(rsp_err), 64'(exp_err));
            chk("eng_quiet", 64'(eng_valid), 64'd0);
            chk("ready_in_resp", 64'(req_ready), 64'd0);
        end
        tick();
        chk("rsp_pulse", 64'(rsp_valid), 64'd0);
        chk("idle", 64'(busy), 64'd0);
    endtask

    task automatic new_req(input int r);
        logic [7:0] ops[7];
        int k, nb;
        ops = '{8'h02, 8'h03, 8'h20, 8'h52, 8'hD8, 8'h99, 8'h00};
        k = $urandom_range(0, 6);
        nb = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 3);
        set_req(r, (k == 6) ? 8'($urandom) : ops[k], 24'($urandom), nb);
    endtask

    initial begin
        logic [7:0]  o;
        logic [23:0] a;
        int cyc;

        rst = 1'b1;
        eng_ready = 1'b0;
        eng_done = 1'b0;
        eng_status = 8'h00;
        for (int r = 0; r < 2; r++) set_req(r, 8'h03, 24'h000100, 0);
        drive_reqs();
        repeat (3) tick();
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp", {61'd0, rsp_valid, rsp_err}, 64'd0);
        chk("reset_eng", {31'd0, eng_valid, eng_op, eng_addr}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        pend_vld[0] = 1'b0;
        pend_vld[1] = 1'b0;
        drive_reqs();
        rst = 1'b0;
        last_g = 1;
        tick();

        set_req(0, 8'h03, 24'h000100, 0);
        run_one();
        set_req(1, 8'h20, 24'h001000, 2);
        run_one();
        set_req(0, 8'h03, 24'h000200, 0);
        set_req(1, 8'h03, 24'h000300, 0);
        run_one();
        set_req(0, 8'h03, 24'h000400, 0);
        run_one();
        run_one();
        set_req(0, 8'h99, 24'h000000, 0);
        run_one();
        set_req(0, 8'hAB, 24'h123456, 0);
        run_one();
        set_req(0, 8'hD8, 24'h0F0000, 9);
        run_one();

        // Reset while the program command is outstanding in the engine.
        set_req(0, 8'h02, 24'h0055AA, 0);
        drive_reqs();
        #1;
        cyc = 0;
        while (req_ready == 2'b00 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rst_grant", 64'(req_ready), 64'd1);
        tick();
        pend_vld[0] = 1'b0;
        drive_reqs();
        serve(o, a, 8'($urandom), 1'b1);
        chk("rst_prefix", 64'(o), 64'h06);
        serve(o, a, 8'($urandom), 1'b0);
        chk("rst_cmd", 64'(o), 64'h02);
        rst = 1'b1;
        tick();
        chk("midrst_eng", {31'd0, eng_valid, eng_op, eng_addr}, 64'd0);
        chk("midrst_rsp", {61'd0, rsp_valid, rsp_err}, 64'd0);
        chk("midrst_busy", {62'd0, busy, req_ready != 2'b00}, 64'd0);
        rst = 1'b0;
        eng_done = 1'b1;
        eng_status = 8'h00;
        tick();
        eng_done = 1'b0;
        chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        chk("midrst_idle", 64'(busy), 64'd0);
        last_g = 1;
        set_req(1, 8'h52, 24'h0A0B0C, 1);
        run_one();

        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend_vld[r] && $urandom_range(0, 1) == 1) new_req(r);
            end
            if (!pend_vld[0] && !pend_vld[1]) new_req($urandom_range(0, 1));
            run_one();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qspi_cmd_scheduler.md
# qspi_cmd_scheduler

Sequences flash commands from two requesters (internal, external) onto the single QSPI command engine. Arbitrates round-robin, inserts the mandatory prefix commands (write-enable before program/erase, reset-enable before reset), and polls the status register until the device clears WIP. Responds to the owning requester with done/error. Sits between the NoC-facing interface and the SPI shift engine.

## Interface
- `ADDR_W`, 24, flash address width.
- `POLL_MAX`, 16'd1000, maximum RDSR polls before timeout. Used only with the macro in Configuration.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: request per requester. Bit0 = internal, bit1 = external.
- `req_op` in 16: opcodes. [7:0] = req0, [15:8] = req1.
- `req_addr` in 2*ADDR_W: addresses. Low slice = req0.
- `req_ready` out 2: one-cycle accept pulse to the granted requester.
- `rsp_valid` out 2: one-cycle completion pulse to the owning requester.
- `rsp_err` out 1: qualifies `rsp_valid`. 1 = illegal opcode or poll timeout.
- `eng_valid` out 1: engine command valid.
- `eng_op` out 8: engine opcode.
- `eng_addr` out ADDR_W: engine address.
- `eng_ready` in 1: engine accepts the command.
- `eng_done` in 1: one-cycle pulse when the engine command completes.
- `eng_status` in 8: status byte. Valid with `eng_done` after RDSR.
- `busy` out 1: high in every state except IDLE.

## Operation
- Legal opcodes: 0x02 write, 0x03 read, 0x20 4K erase, 0x52 32K erase, 0xD8 64K erase, 0x99 reset.
- Prefix commands:
  - 0x02/0x20/0x52/0xD8 get prefix 0x06 (WREN) and RDSR polling.
  - 0x99 gets prefix 0x66 (RSTEN) and no polling.
  - 0x03 gets no prefix and no polling.
- FSM states: IDLE, PRE_ISSUE, PRE_WAIT, CMD_ISSUE, CMD_WAIT, POLL_ISSUE, POLL_WAIT, RESP.
- IDLE:
  - If any `req_valid`: grant per arbiter, pulse `req_ready[g]`, latch op, addr and owner.
  - Next state: PRE_ISSUE if a prefix is needed, else CMD_ISSUE.
  - Illegal opcode: still accepted, go to RESP with err=1, no engine traffic.
- *_ISSUE: hold `eng_valid` with stable `eng_op`/`eng_addr` until `eng_ready`, then go to the matching *_WAIT.
- *_WAIT: wait for `eng_done`.
  - PRE_WAIT -> CMD_ISSUE.
  - CMD_WAIT -> POLL_ISSUE if polling, else RESP.
- POLL_ISSUE: `eng_op`=0x05, `eng_addr`=0.
- POLL_WAIT on `eng_done`:
  - `eng_status[0]`=0 -> RESP with err=0.
  - Else increment the poll counter and return to POLL_ISSUE.
- RESP: pulse `rsp_valid[owner]` and `rsp_err` for one cycle, clear the poll counter, go to IDLE.
- Arbiter: 2-way round-robin with a last-grant pointer.
  - Both valid: grant the one not granted last.
  - Pointer updates only on grant.
  - After reset, requester 0 wins a tie.
- `eng_done` outside a *_WAIT state is ignored.
- `eng_ready` is ignored when `eng_valid`=0.

## Timing
- Reset values:
  - All outputs 0; `eng_op`=0x00, `eng_addr`=0.
  - State IDLE, pointer favours req0, poll counter 0.
- `rst` mid-operation aborts immediately: no `rsp_valid` is issued, and `eng_valid` drops the next cycle.
- Accept at cycle N: `eng_valid` rises at N+1. No combinational path from `req_valid` to `eng_valid`.
- `eng_valid` and `eng_ready` high in the same cycle: accepted that cycle, `eng_valid` low the next.
- `eng_done` at cycle M in the final WAIT: `rsp_valid` at M+1, IDLE at M+2. The earliest next `req_ready` is M+2.
- `req_ready` is never asserted outside IDLE. Requesters must hold `req_valid`/op/addr until `req_ready`.
- `busy` is registered and rises the cycle after accept.

## Configuration
- `QSPI_SCHED_POLL_TIMEOUT_EN` defined:
  - 16-bit poll counter compared against `POLL_MAX`.
  - If WIP is still set on the `POLL_MAX`-th `eng_done`, go to RESP with err=1.
- Undefined:
  - Counter logic absent; polling continues indefinitely.
  - `rsp_err` is set only for illegal opcodes.

## Structure
- Package `qspi_pkg`:
  - Opcode constants: OP_WRITE 0x02, OP_READ 0x03, OP_SE4K 0x20, OP_BE32K 0x52, OP_BE64K 0xD8, OP_RST 0x99, OP_RSTEN 0x66, OP_WREN 0x06, OP_RDSR 0x05.
  - FSM state enum.
  - Functions `needs_wren(op)` and `needs_poll(op)`.
- Sub-module `qspi_rr_arb`: 2-way round-robin arbiter with inputs `req`, `advance` and output `gnt`.

## Test plan
- req0 0x03 addr 0x000100, `eng_ready` immediate -> `req_ready`=01; one engine command 0x03/0x000100; `rsp_valid`=01, `rsp_err`=0.
- req1 0x20 addr 0x001000, status 0x01, 0x01, 0x00 -> engine sequence 0x06, 0x20, 0x05 ×3; `rsp_valid`=10, err=0.
- Both valid from reset, both 0x03 -> req0 granted first, req1 next. Both re-request -> req1 wins the tie (round-robin).
- req0 0x99 -> engine 0x66 then 0x99, no RDSR; `rsp_valid`=01. req0 0xAB -> `rsp_valid`=01, err=1, no `eng_valid`.
- With macro, `POLL_MAX`=4, status stuck 0x01 on 0xD8 -> exactly 4 RDSR, then `rsp_err`=1.
- `rst` asserted during CMD_WAIT of 0x02 -> next cycle all outputs 0, no `rsp_valid`; a new request is accepted normally.
